instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have a parameter PC_RESET, default 32'h0000_0000, meaning the fetch PC after reset.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 imem_rd_en  out  1  instruction-memory read strobe.
REQ-006 imem_addr  out  32  byte address of the read; equals the fetch PC.
REQ-007 imem_rdata  in  32  instruction word; valid exactly one cycle after the cycle with imem_rd_en=1.
REQ-008 jump_en  in  1  redirect request from branch/jump resolution.
REQ-009 jump_addr  in  32  redirect target; sampled when jump_en=1.
REQ-010 deq_en  in  1  dispatch consumed the head entry this cycle.
REQ-011 icode_out  out  32  head instruction word, presented to the dispatch decoder.
REQ-012 pc_out  out  32  PC of the head instruction.
REQ-013 empty  out  1  queue holds no valid entry.
REQ-014 full  out  1  queue holds DEPTH valid entries.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries {icode, pc}, with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
REQ-016 A one-bit in-flight flag plus a 32-bit in-flight PC SHALL track each outstanding read.
REQ-017 imem_rd_en SHALL be 1 combinationally when jump_en=0 and (count + inflight) < DEPTH, counting the entry freed by a same-cycle deq_en.
REQ-018 On each cycle with imem_rd_en=1, the fetch PC SHALL advance by 4 (modulo 2^32 wrap), inflight SHALL be set, and the in-flight PC SHALL capture the fetch PC.
REQ-019 On the cycle after a read, when inflight=1 and no flush occurs, {imem_rdata, in-flight PC} SHALL be written at the tail, the tail SHALL advance, and inflight SHALL clear unless a new read was issued in the same cycle.
REQ-020 deq_en=1 with empty=0 SHALL advance the head and decrement count.
REQ-021 deq_en=1 with empty=1 SHALL be ignored.
REQ-022 A same-cycle write and dequeue SHALL leave count unchanged, including when the queue is full or has one entry.
REQ-023 Flush: jump_en=1 SHALL, at the next edge, clear head, tail, count and inflight, discard any response returning that cycle, and load the fetch PC with jump_addr; flush SHALL take priority over deq_en and writes.
REQ-024 Reads SHALL resume in the cycle after the flush, at jump_addr.
REQ-025 When empty=1, icode_out SHALL be 32'h0000_0000 and pc_out SHALL be 32'h0000_0000, so the decoder selects its invalid-opcode path and no issue queue is enabled.
REQ-026 When empty=0, icode_out and pc_out SHALL come combinationally from the head entry.
REQ-027 The empty and full outputs SHALL be decoded directly from count, with no extra cycle of delay.
REQ-028 Throughput SHALL be one instruction per cycle in steady state, with fetch-to-head latency of 2 cycles: read cycle, then write cycle, with the entry visible at the head in the following cycle.

Reset
REQ-029 While rst=1, the block SHALL hold: fetch PC=PC_RESET, head=tail=count=0, inflight=0, imem_rd_en=0, empty=1, full=0, icode_out=0, pc_out=0.
REQ-030 Reset asserted mid-read SHALL discard the pending response.
REQ-031 Storage array contents SHALL NOT require reset.
REQ-032 The first read SHALL occur in the first cycle after rst deasserts.

Verification
REQ-033 Reset release, memory returning addr-tagged words, deq_en=0 -> reads at 0x0, 0x4, 0x8, 0xC; full=1 after 4 writes; imem_rd_en=0 thereafter.
REQ-034 Full queue, deq_en=1 held continuously -> one word per cycle at icode_out; pc_out sequence 0x0, 0x4, 0x8, ...; count stays at 3-4; no loss or duplication.
REQ-035 jump_en=1, jump_addr=0x100 while 3 entries are queued and 1 read is in flight -> next cycle empty=1, icode_out=0; the next read is at 0x100; the stale response is not enqueued.
REQ-036 Same cycle jump_en=1 and deq_en=1 -> flush wins; count=0; fetch PC=jump_addr.
REQ-037 deq_en=1 while empty -> no pointer movement; count stays 0; no underflow.
REQ-038 rst asserted in the cycle after a read, then released -> fetch PC=PC_RESET, empty=1, and the returning word is not stored.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential instruction-memory reads and buffers
// the returned words with their PCs in a circular buffer for the dispatch stage.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        deq_en,
  output logic [31:0] icode_out,
  output logic [31:0] pc_out,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0] icode_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;

  logic          deq_ok;
  logic          wr_en;
  logic          rd_en;
  logic [CW-1:0] occupancy;

  // Reads are throttled so that queued entries plus the outstanding response
  // never exceed DEPTH, crediting the slot freed by a same-cycle dequeue.
  always_comb begin
    deq_ok    = deq_en && (count_q != '0);
    wr_en     = inflight_q && !jump_en;
    occupancy = count_q + CW'(inflight_q) - CW'(deq_ok);
    rd_en     = !rst && !jump_en && (occupancy < DEPTH_C);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (jump_en) begin
      // Redirect discards everything, including a response arriving this cycle.
      fetch_pc_d = jump_addr;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (rd_en) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_pc_d = fetch_pc_q;
      end
      if (wr_en) begin
        tail_d = tail_q + AW'(1);
      end
      if (deq_ok) begin
        head_d = head_q + AW'(1);
      end
      inflight_d = rd_en;
      count_d    = count_q + CW'(wr_en) - CW'(deq_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= PC_RESET;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Storage needs no reset; only entries between head and tail are ever observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      icode_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q]    <= inflight_pc_q;
    end
  end

  assign imem_rd_en = rd_en;
  assign imem_addr  = fetch_pc_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == DEPTH_C);
  assign icode_out  = empty ? 32'h0000_0000 : icode_mem[head_q];
  assign pc_out     = empty ? 32'h0000_0000 : pc_mem[head_q];

endmodule
